// File: rtl/fp32_pkg.sv
// Shared FP32 format constants and helpers for the neuron datapath.
package fp32_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // An all-ones exponent marks inf or NaN.
  function automatic logic fp32_is_special(input logic [FP32_EXP_W-1:0] exp);
    return (exp == {FP32_EXP_W{1'b1}});
  endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Combinational 24-bit leading-zero counter; returns 24 for an all-zero input.
module fp_lzc24 (
  input  logic [23:0] d,
  output logic [4:0]  cnt
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (d[i]) cnt = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp32_add_sub.sv
// FP32 adder/subtractor with truncating rounding and one output register stage.
// Denormal inputs are flushed to zero; inf/NaN inputs raise the exception flag.
module fp32_add_sub
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        add_sub_signal,
  output logic        exception,
  output logic [31:0] result
);

  logic                  sign_a_p0, sign_b_p0;
  logic                  zero_a_p0, zero_b_p0;
  logic                  special_p0;
  logic [30:0]           mag_a_p0, mag_b_p0;
  logic                  a_big_p0;
  logic                  sign_l_p0;
  logic [30:0]           mag_l_p0, mag_s_p0;
  logic [FP32_EXP_W-1:0] exp_l_p0, exp_s_p0, diff_p0;
  logic [23:0]           sig_l_p0, sig_s_p0, sig_s_al_p0;
  logic [24:0]           sum_p0;
  logic [23:0]           dif_p0;
  logic [4:0]            lzc_p0;
  logic signed [9:0]     exp_n_p0;
  logic [22:0]           man_n_p0;
  logic [31:0]           res_p0;
  logic                  exc_p0;

  logic [31:0]           result_p1;
  logic                  exception_p1;

  // Saturating pack: exponent overflow becomes signed inf, underflow becomes signed zero.
  function automatic logic [31:0] pack_sat(input logic s, input logic signed [9:0] e,
                                           input logic [22:0] m);
    if (e >= 10'sd255)
      return {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)
      return {s, 31'd0};
    else
      return {s, e[7:0], m};
  endfunction

  // ---- stage p0: unpack, swap, align, add/sub (combinational) ----
  assign sign_a_p0  = a[31];
  assign sign_b_p0  = b[31] ^ add_sub_signal;
  assign zero_a_p0  = (a[30:23] == '0);
  assign zero_b_p0  = (b[30:23] == '0);
  assign special_p0 = fp32_is_special(a[30:23]) || fp32_is_special(b[30:23]);
  assign mag_a_p0   = zero_a_p0 ? 31'd0 : a[30:0];
  assign mag_b_p0   = zero_b_p0 ? 31'd0 : b[30:0];

  assign a_big_p0  = (mag_a_p0 >= mag_b_p0);
  assign sign_l_p0 = a_big_p0 ? sign_a_p0 : sign_b_p0;
  assign mag_l_p0  = a_big_p0 ? mag_a_p0 : mag_b_p0;
  assign mag_s_p0  = a_big_p0 ? mag_b_p0 : mag_a_p0;
  assign exp_l_p0  = mag_l_p0[30:23];
  assign exp_s_p0  = mag_s_p0[30:23];
  assign sig_l_p0  = {1'b1, mag_l_p0[22:0]};
  assign sig_s_p0  = {1'b1, mag_s_p0[22:0]};
  assign diff_p0   = exp_l_p0 - exp_s_p0;

  assign sig_s_al_p0 = (diff_p0 >= 8'd25) ? 24'd0 : (sig_s_p0 >> diff_p0);
  assign sum_p0      = {1'b0, sig_l_p0} + {1'b0, sig_s_al_p0};
  assign dif_p0      = sig_l_p0 - sig_s_al_p0;

  fp_lzc24 u_lzc (
    .d   (dif_p0),
    .cnt (lzc_p0)
  );

  // Normalise and select the special-case results ahead of the output register.
  always_comb begin
    res_p0   = 32'd0;
    exc_p0   = 1'b0;
    exp_n_p0 = 10'sd0;
    man_n_p0 = 23'd0;
    if (special_p0) begin
      res_p0 = FP32_QNAN;
      exc_p0 = 1'b1;
    end else if (zero_a_p0 && zero_b_p0) begin
      res_p0 = 32'd0;
    end else if (zero_a_p0) begin
      res_p0 = {sign_b_p0, mag_b_p0};
    end else if (zero_b_p0) begin
      res_p0 = {sign_a_p0, mag_a_p0};
    end else if (sign_a_p0 == sign_b_p0) begin
      if (sum_p0[24]) begin
        man_n_p0 = sum_p0[23:1];
        exp_n_p0 = $signed({2'b00, exp_l_p0}) + 10'sd1;
      end else begin
        man_n_p0 = sum_p0[22:0];
        exp_n_p0 = $signed({2'b00, exp_l_p0});
      end
      res_p0 = pack_sat(sign_l_p0, exp_n_p0, man_n_p0);
    end else if (dif_p0 == 24'd0) begin
      res_p0 = 32'd0;
    end else begin
      man_n_p0 = 23'(dif_p0 << lzc_p0);
      exp_n_p0 = $signed({2'b00, exp_l_p0}) - $signed({5'b00000, lzc_p0});
      res_p0   = pack_sat(sign_l_p0, exp_n_p0, man_n_p0);
    end
  end

  // ---- stage p1: output register ----
  // Output register; async reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p1    <= 32'd0;
      exception_p1 <= 1'b0;
    end else begin
      result_p1    <= res_p0;
      exception_p1 <= exc_p0;
    end
  end

  assign result    = result_p1;
  assign exception = exception_p1;

endmodule

// File: tb/tb_fp32_add_sub.sv
// Scoreboard bench for fp32_add_sub: driver queues expected results, monitor checks them.
module tb_fp32_add_sub;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic        add_sub_signal;
  logic        exception;
  logic [31:0] result;

  typedef struct {
    int          id;
    logic [31:0] r;
    logic        e;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  fp32_add_sub dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a              (a),
    .b              (b),
    .add_sub_signal (add_sub_signal),
    .exception      (exception),
    .result         (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Apply one operand set at the falling edge and queue its expected response.
  task automatic issue(input int id, input logic [31:0] ta, input logic [31:0] tb,
                       input logic op, input logic [31:0] er, input logic ee);
    exp_t x;
    @(negedge clk);
    a = ta;
    b = tb;
    add_sub_signal = op;
    x.id = id;
    x.r  = er;
    x.e  = ee;
    sb_q.push_back(x);
  endtask

  // Monitor: one result per cycle, checked just after the capturing edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk($sformatf("vec%0d_result", x.id), result, x.r);
        chk($sformatf("vec%0d_exception", x.id), {31'd0, exception}, {31'd0, x.e});
      end
    end
  end

  initial begin
    int wait_cyc;
    rst_n = 1'b0;
    a = 32'd0;
    b = 32'd0;
    add_sub_signal = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_exception", {31'd0, exception}, 32'd0);
    rst_n = 1'b1;

    issue(1,  32'h415EB852, 32'h40DEB852, 1'b0, 32'h41A70A3D, 1'b0);
    issue(2,  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
    issue(3,  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0);
    issue(4,  32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, 1'b0);
    issue(5,  32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1);
    issue(6,  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
    issue(7,  32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0);
    issue(8,  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0);
    issue(9,  32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 1'b0);
    issue(10, 32'hC0A00000, 32'h00000000, 1'b0, 32'hC0A00000, 1'b0);
    issue(11, 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0);
    issue(12, 32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 1'b0);
    issue(13, 32'h4C000000, 32'h3F800000, 1'b0, 32'h4C000000, 1'b0);
    issue(14, 32'h40000000, 32'h34800000, 1'b1, 32'h3FFFFFFE, 1'b0);
    issue(15, 32'hC0000000, 32'hC0000000, 1'b0, 32'hC0800000, 1'b0);
    issue(16, 32'h3F800000, 32'h7FC00001, 1'b1, 32'h7FC00000, 1'b1);

    // Reset pulse between edges while a flagged result sits in the register.
    @(negedge clk);
    a = 32'h7F800000;
    b = 32'h3F800000;
    add_sub_signal = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_exception", {31'd0, exception}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_result", result, 32'd0);
    chk("midreset_exception", {31'd0, exception}, 32'd0);
    #1 rst_n = 1'b1;

    issue(20, 32'h40400000, 32'h40A00000, 1'b0, 32'h41000000, 1'b0);
    issue(21, 32'h40A00000, 32'h40400000, 1'b1, 32'h40000000, 1'b0);
    issue(22, 32'h3F800000, 32'h00000000, 1'b1, 32'h3F800000, 1'b0);
    issue(23, 32'h415EB852, 32'h40DEB852, 1'b1, 32'h40DEB852, 1'b0);

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb_q.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
